collision_monitor: RTL and testbench

Parametrised multi-channel collision detector for the drive controller. It samples NUM_CH active-low proximity sensors and selects the channels relevant to the current travel direction. Each channel is debounced independently, with separate assert and release times. A drive/stop FSM adds a restart hold-off and an optional latched-stop mode, and outputs the drive enable, a per-channel hit mask and three status LEDs.

---
 rtl/collision_pkg.sv | 29 ++
 rtl/collision_monitor_debounce.sv | 51 +++++
 rtl/collision_monitor.sv | 109 ++++++++++
 tb/tb_collision_monitor.sv | 156 +++++++++++++++
 4 files changed

// File: rtl/collision_pkg.sv
// collision_pkg: shared encodings for the collision monitor.
//   state_e       drive/stop FSM states
//   LED_*         one-hot status LED patterns
//   DRV_ON/OFF    drive output levels
//   FORWARDS/...  direction input levels
//   max_int       helper for counter sizing
package collision_pkg;

  typedef enum logic [1:0] {
    ST_DRIVE   = 2'd0,
    ST_HOLDOFF = 2'd1,
    ST_STOP    = 2'd2
  } state_e;

  localparam logic [2:0] LED_DRIVE   = 3'b001;
  localparam logic [2:0] LED_HOLDOFF = 3'b010;
  localparam logic [2:0] LED_STOP    = 3'b100;

  localparam logic DRV_ON  = 1'b1;
  localparam logic DRV_OFF = 1'b0;

  localparam logic FORWARDS  = 1'b1;
  localparam logic BACKWARDS = 1'b0;

  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/collision_monitor_debounce.sv
// sensor_debounce: one proximity channel.
//   clk, rst  clock / async active-low reset
//   sens      raw active-low sensor line (asynchronous)
//   hit       debounced obstacle flag
// A 2-flop synchroniser feeds a single counter that measures how long the
// synchronised input has disagreed with the current hit state. The
// counter is reused for both the assert and release directions.
module sensor_debounce
  import collision_pkg::*;
#(
  parameter int ASSERT_CYC  = 50000,
  parameter int RELEASE_CYC = 50000
) (
  input  logic clk,
  input  logic rst,
  input  logic sens,
  output logic hit
);

  localparam int CW = $clog2(max_int(ASSERT_CYC, RELEASE_CYC) + 1);
  localparam logic [CW-1:0] A_LAST = CW'(ASSERT_CYC - 1);
  localparam logic [CW-1:0] R_LAST = CW'(RELEASE_CYC - 1);

  logic [1:0]    sync;
  logic [CW-1:0] cnt;
  logic          raw_hit;
  logic          toward;   // input disagrees with current hit state

  assign raw_hit = ~sync[1];
  assign toward  = hit ? ~raw_hit : raw_hit;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sync <= 2'b11;
      cnt  <= '0;
      hit  <= 1'b0;
    end else begin
      sync <= {sync[0], sens};
      if (!toward) begin
        cnt <= '0;
      end else if (cnt == (hit ? R_LAST : A_LAST)) begin
        // Counter stops at the threshold, so it can never wrap.
        hit <= ~hit;
        cnt <= '0;
      end else begin
        cnt <= cnt + 1'b1;
      end
    end
  end

endmodule

// File: rtl/collision_monitor.sv
// collision_monitor: multi-channel collision detector with drive/stop FSM.
//   clk, rst   clock / async active-low reset
//   direction  1 = forwards, 0 = backwards (used unsynchronised)
//   sens       NUM_CH raw active-low sensor lines
//   clr_latch  pulse releasing a latched stop (LATCH=1 only)
//   drive      1 = drive permitted
//   hit_mask   debounced hit per channel, independent of direction
//   col_event  one-cycle pulse on DRIVE->STOP
//   led        one-hot state 001 DRIVE / 010 HOLDOFF / 100 STOP
module collision_monitor
  import collision_pkg::*;
#(
  parameter int              NUM_CH      = 4,
  parameter int              ASSERT_CYC  = 50000,
  parameter int              RELEASE_CYC = 50000,
  parameter int              HOLD_CYC    = 50000,
  parameter logic [NUM_CH-1:0] FWD_MASK  = NUM_CH'(4'b0011),
  parameter logic [NUM_CH-1:0] BWD_MASK  = NUM_CH'(4'b1100),
  parameter bit              LATCH       = 1'b0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              direction,
  input  logic [NUM_CH-1:0] sens,
  input  logic              clr_latch,
  output logic              drive,
  output logic [NUM_CH-1:0] hit_mask,
  output logic              col_event,
  output logic [2:0]        led
);

  localparam int HW = $clog2(HOLD_CYC + 1);
  localparam logic [HW-1:0] HOLD_LAST = HW'(HOLD_CYC - 1);

  state_e            state;
  logic [HW-1:0]     hold_cnt;
  logic [NUM_CH-1:0] active;
  logic              any_active;

  genvar g;
  generate
    for (g = 0; g < NUM_CH; g++) begin : g_ch
      sensor_debounce #(
        .ASSERT_CYC (ASSERT_CYC),
        .RELEASE_CYC(RELEASE_CYC)
      ) u_deb (
        .clk (clk),
        .rst (rst),
        .sens(sens[g]),
        .hit (hit_mask[g])
      );
    end
  endgenerate

  assign active     = hit_mask & ((direction == FORWARDS) ? FWD_MASK : BWD_MASK);
  assign any_active = |active;

  // drive/led are loaded together with the next state so they are plain
  // register outputs with no decode glitches.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= ST_HOLDOFF;
      hold_cnt  <= '0;
      drive     <= DRV_OFF;
      col_event <= 1'b0;
      led       <= LED_HOLDOFF;
    end else begin
      col_event <= 1'b0;
      case (state)
        ST_DRIVE: begin
          if (any_active) begin
            state     <= ST_STOP;
            drive     <= DRV_OFF;
            led       <= LED_STOP;
            col_event <= 1'b1;
          end
        end
        ST_STOP: begin
          // A clr_latch seen while still blocked is simply dropped.
          if (!any_active && (!LATCH || clr_latch)) begin
            state    <= ST_HOLDOFF;
            hold_cnt <= '0;
            led      <= LED_HOLDOFF;
          end
        end
        ST_HOLDOFF: begin
          // Hit wins over hold completion; re-stop is silent.
          if (any_active) begin
            state <= ST_STOP;
            led   <= LED_STOP;
          end else if (hold_cnt == HOLD_LAST) begin
            state    <= ST_DRIVE;
            hold_cnt <= '0;
            drive    <= DRV_ON;
            led      <= LED_DRIVE;
          end else begin
            hold_cnt <= hold_cnt + 1'b1;
          end
        end
        default: begin
          state <= ST_STOP;
          drive <= DRV_OFF;
          led   <= LED_STOP;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_collision_monitor.sv
// Bench for collision_monitor: two instances (LATCH=0 and LATCH=1) with
// ASSERT_CYC=4, RELEASE_CYC=4, HOLD_CYC=8, driven from vector tables.
// Inputs change on the falling edge; outputs are sampled on falling edges.
module tb_collision_monitor;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst, dir, clr, drive, col;
  logic [3:0] sens, hit;
  logic [2:0] led;
  logic       l_rst, l_dir, l_clr, l_drive, l_col;
  logic [3:0] l_sens, l_hit;
  logic [2:0] l_led;

  collision_monitor #(.NUM_CH(4), .ASSERT_CYC(4), .RELEASE_CYC(4), .HOLD_CYC(8),
                      .FWD_MASK(4'b0011), .BWD_MASK(4'b1100), .LATCH(1'b0)) u_dut (
    .clk(clk), .rst(rst), .direction(dir), .sens(sens), .clr_latch(clr),
    .drive(drive), .hit_mask(hit), .col_event(col), .led(led));

  collision_monitor #(.NUM_CH(4), .ASSERT_CYC(4), .RELEASE_CYC(4), .HOLD_CYC(8),
                      .FWD_MASK(4'b0011), .BWD_MASK(4'b1100), .LATCH(1'b1)) u_lat (
    .clk(clk), .rst(l_rst), .direction(l_dir), .sens(l_sens), .clr_latch(l_clr),
    .drive(l_drive), .hit_mask(l_hit), .col_event(l_col), .led(l_led));

  typedef struct {
    string      name;
    logic       rst;
    logic       dir;
    logic [3:0] sens;
    logic       clr;
    int         n;      // rising edges to advance before checking
    logic       drv;
    logic [2:0] led;
    logic [3:0] hit;
    logic       col;
  } vec_t;

  typedef struct {
    string      name;
    logic       drv;
    logic [2:0] led;
    logic [3:0] hit;
    logic       col;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;
  vec_t mv[23];
  vec_t lv[16];

  function automatic vec_t mk(string nm, logic r, logic d, logic [3:0] s, logic c, int n,
                              logic dv, logic [2:0] ld, logic [3:0] h, logic cl);
    vec_t v;
    v.name = nm; v.rst = r; v.dir = d; v.sens = s; v.clr = c; v.n = n;
    v.drv = dv; v.led = ld; v.hit = h; v.col = cl;
    return v;
  endfunction

  task automatic cmp(input string nm, input string fld, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s.%s: got %0h expected %0h", nm, fld, act, exp);
    end
  endtask

  task automatic run(input vec_t v, input bit lat);
    exp_t e;
    if (lat) begin
      l_rst = v.rst; l_dir = v.dir; l_sens = v.sens; l_clr = v.clr;
    end else begin
      rst = v.rst; dir = v.dir; sens = v.sens; clr = v.clr;
    end
    e.name = v.name; e.drv = v.drv; e.led = v.led; e.hit = v.hit; e.col = v.col;
    sb.push_back(e);
    if (v.n == 0) #1;
    else repeat (v.n) begin @(posedge clk); @(negedge clk); end
    e = sb.pop_front();
    if (lat) begin
      cmp(e.name, "drive", 32'(l_drive), 32'(e.drv));
      cmp(e.name, "led",   32'(l_led),   32'(e.led));
      cmp(e.name, "hit",   32'(l_hit),   32'(e.hit));
      cmp(e.name, "col",   32'(l_col),   32'(e.col));
    end else begin
      cmp(e.name, "drive", 32'(drive), 32'(e.drv));
      cmp(e.name, "led",   32'(led),   32'(e.led));
      cmp(e.name, "hit",   32'(hit),   32'(e.hit));
      cmp(e.name, "col",   32'(col),   32'(e.col));
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1, "watchdog");
  end

  initial begin
    //           name            rst dir sens  clr  n  drv led     hit    col
    mv[0]  = mk("reset",         1, 1, 4'hF, 0,  0, 0, 3'b010, 4'h0, 0);
    mv[1]  = mk("hold7",         1, 1, 4'hF, 0,  7, 0, 3'b010, 4'h0, 0);
    mv[2]  = mk("first_drive",   1, 1, 4'hF, 0,  1, 1, 3'b001, 4'h0, 0);
    mv[3]  = mk("glitch",        1, 1, 4'hE, 0,  3, 1, 3'b001, 4'h0, 0);
    mv[4]  = mk("glitch_end",    1, 1, 4'hF, 0,  6, 1, 3'b001, 4'h0, 0);
    mv[5]  = mk("pre_hit",       1, 1, 4'hE, 0,  5, 1, 3'b001, 4'h0, 0);
    mv[6]  = mk("hit_t6",        1, 1, 4'hE, 0,  1, 1, 3'b001, 4'h1, 0);
    mv[7]  = mk("stop_t7",       1, 1, 4'hE, 0,  1, 0, 3'b100, 4'h1, 1);
    mv[8]  = mk("col_once",      1, 1, 4'hE, 0,  1, 0, 3'b100, 4'h1, 0);
    mv[9]  = mk("rel_t5",        1, 1, 4'hF, 0,  5, 0, 3'b100, 4'h1, 0);
    mv[10] = mk("rel_t6",        1, 1, 4'hF, 0,  1, 0, 3'b100, 4'h0, 0);
    mv[11] = mk("hold_enter",    1, 1, 4'hF, 0,  1, 0, 3'b010, 4'h0, 0);
    mv[12] = mk("hold_t7",       1, 1, 4'hF, 0,  7, 0, 3'b010, 4'h0, 0);
    mv[13] = mk("resume",        1, 1, 4'hF, 0,  1, 1, 3'b001, 4'h0, 0);
    mv[14] = mk("stop2",         1, 1, 4'hE, 0,  7, 0, 3'b100, 4'h1, 1);
    mv[15] = mk("hold2",         1, 1, 4'hF, 0,  7, 0, 3'b010, 4'h0, 0);
    mv[16] = mk("reassert_hit",  1, 1, 4'hE, 0,  6, 0, 3'b010, 4'h1, 0);
    mv[17] = mk("reassert_stop", 1, 1, 4'hE, 0,  1, 0, 3'b100, 4'h1, 0);
    mv[18] = mk("resume2",       1, 1, 4'hF, 0, 15, 1, 3'b001, 4'h0, 0);
    mv[19] = mk("bwd_ch_in_fwd", 1, 1, 4'h7, 0,  8, 1, 3'b001, 4'h8, 0);
    mv[20] = mk("dir_switch",    1, 0, 4'h7, 0,  1, 0, 3'b100, 4'h8, 1);
    mv[21] = mk("dir_col_once",  1, 0, 4'h7, 0,  1, 0, 3'b100, 4'h8, 0);
    mv[22] = mk("async_rst",     0, 0, 4'h7, 0,  0, 0, 3'b010, 4'h0, 0);

    lv[0]  = mk("l_reset",       1, 1, 4'hF, 0,  0, 0, 3'b010, 4'h0, 0);
    lv[1]  = mk("l_drive",       1, 1, 4'hF, 0,  8, 1, 3'b001, 4'h0, 0);
    lv[2]  = mk("l_stop",        1, 1, 4'hE, 0,  7, 0, 3'b100, 4'h1, 1);
    lv[3]  = mk("l_held",        1, 1, 4'hF, 0, 20, 0, 3'b100, 4'h0, 0);
    lv[4]  = mk("l_reassert",    1, 1, 4'hE, 0,  7, 0, 3'b100, 4'h1, 0);
    lv[5]  = mk("l_clr_blocked", 1, 1, 4'hE, 1,  1, 0, 3'b100, 4'h1, 0);
    lv[6]  = mk("l_clr_low",     1, 1, 4'hE, 0,  1, 0, 3'b100, 4'h1, 0);
    lv[7]  = mk("l_not_remembr", 1, 1, 4'hF, 0, 10, 0, 3'b100, 4'h0, 0);
    lv[8]  = mk("l_clr_ok",      1, 1, 4'hF, 1,  1, 0, 3'b010, 4'h0, 0);
    lv[9]  = mk("l_hold7",       1, 1, 4'hF, 0,  7, 0, 3'b010, 4'h0, 0);
    lv[10] = mk("l_resume",      1, 1, 4'hF, 0,  1, 1, 3'b001, 4'h0, 0);
    lv[11] = mk("l_stop2",       1, 1, 4'hE, 0,  7, 0, 3'b100, 4'h1, 1);
    lv[12] = mk("l_held2",       1, 1, 4'hF, 0, 10, 0, 3'b100, 4'h0, 0);
    lv[13] = mk("l_clr2",        1, 1, 4'hF, 1,  1, 0, 3'b010, 4'h0, 0);
    lv[14] = mk("l_mid_hold",    1, 1, 4'hF, 0,  3, 0, 3'b010, 4'h0, 0);
    lv[15] = mk("l_async_rst",   0, 1, 4'hF, 0,  0, 0, 3'b010, 4'h0, 0);

    rst = 1'b0; dir = 1'b1; sens = 4'hF; clr = 1'b0;
    l_rst = 1'b0; l_dir = 1'b1; l_sens = 4'hF; l_clr = 1'b0;
    repeat (3) @(negedge clk);

    foreach (mv[i]) run(mv[i], 1'b0);
    @(negedge clk);
    foreach (lv[i]) run(lv[i], 1'b1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
